// File: rtl/load_store_unit.sv
// load_store_unit: bridges CPU load/store requests to a word-wide memory.
// Byte/half/word loads are extracted from the memory word and sign- or zero-extended.
// Word stores go straight to memory. Sub-word stores read the word, merge the new lane
// and write the word back.
// Misaligned accesses and illegal sizes complete with an error and no memory access.
// An ack that does not arrive within ACK_TIMEOUT wait cycles also completes with an error.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   req_i .. wdata_i    request: we, size, unsigned, byte address, right-aligned store data
//   busy_o              high in every state except idle
//   done_o, err_o       one-cycle completion pulse and its error flag
//   rdata_o             last successful load result
//   mem_*               single-cycle rd/wr strobes, word address, write data, read data, ack
module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    typedef enum logic [2:0] {StIdle, StRd, StRdWait, StWr, StWrWait, StDone} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic [31:0] cnt_q, cnt_d;

    logic        misaligned;
    logic        timeout_hit;
    logic [4:0]  lane_sh;
    logic [31:0] shifted;
    logic [31:0] extracted;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    assign misaligned = (size_i == 2'b11) ||
                        (size_i == 2'b01 && addr_i[0]) ||
                        (size_i == 2'b10 && addr_i[1:0] != 2'b00);

    // Fires on the wait cycle that would be the ACK_TIMEOUT-th without an ack.
    assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q + 32'd1 == ACK_TIMEOUT);

    // Halves are aligned, so the byte-offset shift also selects the correct half lane.
    assign lane_sh = {addr_q[1:0], 3'b000};
    assign shifted = mem_data_i >> lane_sh;

    always_comb begin
        extracted = mem_data_i;
        lane_mask = 32'h0000_00ff << lane_sh;
        merged    = (mem_data_i & ~lane_mask) | ({24'h0, wdata_q[7:0]} << lane_sh);
        if (size_q == 2'b00) begin
            extracted = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        end else if (size_q == 2'b01) begin
            extracted = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            lane_mask = 32'h0000_ffff << lane_sh;
            merged    = (mem_data_i & ~lane_mask) | ({16'h0, wdata_q} << lane_sh);
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        mem_data_d = mem_data_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i[15:0];
                    err_d   = misaligned;
                    if (misaligned) begin
                        state_d = StDone;
                    end else if (we_i && size_i == 2'b10) begin
                        mem_data_d = wdata_i;
                        state_d    = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                cnt_d   = 32'd0;
                state_d = StRdWait;
            end
            StRdWait: begin
                if (mem_ack_i) begin
                    if (we_q) begin
                        mem_data_d = merged;
                        state_d    = StWr;
                    end else begin
                        rdata_d = extracted;
                        state_d = StDone;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StWr: begin
                cnt_d   = 32'd0;
                state_d = StWrWait;
            end
            StWrWait: begin
                if (mem_ack_i) begin
                    state_d = StDone;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 16'h0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            mem_data_q <= 32'h0;
            cnt_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_data_q <= mem_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign err_o       = (state_q == StDone) && err_q;
    assign rdata_o     = rdata_q;
    assign mem_rd_en_o = (state_q == StRd);
    assign mem_wr_en_o = (state_q == StWr);
    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_data_o  = mem_data_q;

endmodule
